load_store_issuer: RTL and testbench

LOAD_STORE_ISSUER -- requirements
Module: load_store_issuer

---
 rtl/load_store_pkg.sv | 39 +++
 rtl/lsi_latency_counter.sv | 37 +++
 rtl/load_store_issuer.sv | 152 +++++++++++++++
 tb/tb_load_store_issuer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
// Shared definitions for the load/store issuer and the LoadStoreUnit:
// funct3 encodings, issuer FSM state type and the funct3 legality check.
package load_store_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } lsi_state_e;

    // Stores accept byte/half/word only; loads add the unsigned byte/half forms.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                SB, SH, SW: ok = 1'b1;
                default:    ok = 1'b0;
            endcase
        end else begin
            case (f3)
                LB, LH, LW, LBU, LHU: ok = 1'b1;
                default:              ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsi_latency_counter.sv
// Down-counter timing the load WAIT phase: loaded with the read latency,
// done_o marks the final wait cycle (count == 1).
module lsi_latency_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/load_store_issuer.sv
// Single-outstanding load/store issuer between the pipeline and the LoadStoreUnit.
// Optional LOAD_STORE_ISSUER_STATS_EN adds completed-response counters.
module load_store_issuer
    import load_store_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TAG_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             rsp_is_load,
`ifdef LOAD_STORE_ISSUER_STATS_EN
    output logic [31:0]      load_count,
    output logic [31:0]      store_count,
    output logic [31:0]      err_count,
`endif
    output logic [31:0]      lsu_address,
    output logic             lsu_wren,
    output logic [2:0]       lsu_funct3,
    output logic [31:0]      lsu_din,
    input  logic [31:0]      lsu_dout
);

    lsi_state_e state_d, state_q;
    logic       ready_en_q;
    logic       we_q;
    logic       accept, legal;
    logic       cnt_load, cnt_dec, cnt_done, capture;

    assign accept = req_valid && req_ready;
    assign legal  = funct3_legal(req_we, req_funct3);

    lsi_latency_counter #(
        .Width (4)
    ) u_wait_cnt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (cnt_load),
        .load_val_i (4'(READ_LATENCY)),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    // Next-state logic and wait-timer control.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = legal ? StIssue : StResp;
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StResp;
                end else begin
                    state_d  = StWait;
                    cnt_load = 1'b1;
                end
            end
            StWait: begin
                if (cnt_done) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; ready_en_q keeps req_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Latch payload at acceptance; illegal requests leave the LSU-facing outputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_address <= '0;
            lsu_funct3  <= '0;
            lsu_din     <= '0;
            we_q        <= 1'b0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
            rsp_err     <= 1'b0;
            rsp_is_load <= 1'b0;
        end else if (accept) begin
            rsp_tag     <= req_tag;
            rsp_err     <= !legal;
            rsp_is_load <= !req_we;
            rsp_data    <= '0;
            if (legal) begin
                lsu_address <= req_addr;
                lsu_funct3  <= req_funct3;
                lsu_din     <= req_wdata;
                we_q        <= req_we;
            end
        end else if (capture) begin
            rsp_data <= lsu_dout;
        end
    end

    assign req_ready = ready_en_q && (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign lsu_wren  = (state_q == StIssue) && we_q;

`ifdef LOAD_STORE_ISSUER_STATS_EN
    logic [31:0] load_cnt_q, store_cnt_q, err_cnt_q;

    // Count completed response handshakes by kind; errors are counted only as errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_err)          err_cnt_q   <= err_cnt_q + 32'd1;
            else if (rsp_is_load) load_cnt_q  <= load_cnt_q + 32'd1;
            else                  store_cnt_q <= store_cnt_q + 32'd1;
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
    assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_issuer.sv
// Directed bench: one issuer with READ_LATENCY=1 and one with READ_LATENCY=3 share
// stimulus; use3 selects which one a scenario drives. A small LSU memory model
// supplies lsu_dout only in the cycle before the expected capture edge.
module tb_load_store_issuer;
    import load_store_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, use3;
    logic [31:0] req_addr, req_wdata;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [4:0]  req_tag;
    logic        rsp_ready;
    logic [31:0] lsu_dout;

    logic        req_ready1, rsp_valid1, rsp_err1, rsp_is_load1, lsu_wren1;
    logic [31:0] rsp_data1, lsu_address1, lsu_din1;
    logic [4:0]  rsp_tag1;
    logic [2:0]  lsu_funct31;
    logic        req_ready3, rsp_valid3, rsp_err3, rsp_is_load3, lsu_wren3;
    logic [31:0] rsp_data3, lsu_address3, lsu_din3;
    logic [4:0]  rsp_tag3;
    logic [2:0]  lsu_funct33;
`ifdef LOAD_STORE_ISSUER_STATS_EN
    logic [31:0] ld_cnt1, st_cnt1, er_cnt1, ld_cnt3, st_cnt3, er_cnt3;
`endif

    logic        req_valid1, req_valid3;
    assign req_valid1 = req_valid && !use3;
    assign req_valid3 = req_valid && use3;

    // Views of whichever DUT the current scenario drives.
    logic        req_ready_m, rsp_valid_m, rsp_err_m, rsp_is_load_m, lsu_wren_m;
    logic [31:0] rsp_data_m, lsu_address_m, lsu_din_m;
    logic [4:0]  rsp_tag_m;
    logic [2:0]  lsu_funct3_m;
    assign req_ready_m   = use3 ? req_ready3   : req_ready1;
    assign rsp_valid_m   = use3 ? rsp_valid3   : rsp_valid1;
    assign rsp_err_m     = use3 ? rsp_err3     : rsp_err1;
    assign rsp_is_load_m = use3 ? rsp_is_load3 : rsp_is_load1;
    assign lsu_wren_m    = use3 ? lsu_wren3    : lsu_wren1;
    assign rsp_data_m    = use3 ? rsp_data3    : rsp_data1;
    assign lsu_address_m = use3 ? lsu_address3 : lsu_address1;
    assign lsu_din_m     = use3 ? lsu_din3     : lsu_din1;
    assign rsp_tag_m     = use3 ? rsp_tag3     : rsp_tag1;
    assign lsu_funct3_m  = use3 ? lsu_funct33  : lsu_funct31;

    load_store_issuer #(.READ_LATENCY(1), .TAG_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .req_funct3(req_funct3), .req_tag(req_tag),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data1), .rsp_tag(rsp_tag1), .rsp_err(rsp_err1),
        .rsp_is_load(rsp_is_load1),
`ifdef LOAD_STORE_ISSUER_STATS_EN
        .load_count(ld_cnt1), .store_count(st_cnt1), .err_count(er_cnt1),
`endif
        .lsu_address(lsu_address1), .lsu_wren(lsu_wren1), .lsu_funct3(lsu_funct31),
        .lsu_din(lsu_din1), .lsu_dout(lsu_dout)
    );

    load_store_issuer #(.READ_LATENCY(3), .TAG_W(5)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .req_funct3(req_funct3), .req_tag(req_tag),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data3), .rsp_tag(rsp_tag3), .rsp_err(rsp_err3),
        .rsp_is_load(rsp_is_load3),
`ifdef LOAD_STORE_ISSUER_STATS_EN
        .load_count(ld_cnt3), .store_count(st_cnt3), .err_count(er_cnt3),
`endif
        .lsu_address(lsu_address3), .lsu_wren(lsu_wren3), .lsu_funct3(lsu_funct33),
        .lsu_din(lsu_din3), .lsu_dout(lsu_dout)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] mem [0:15];
    int exp_ld [2];
    int exp_st [2];
    int exp_er [2];

    // LSU read model: word-indexed memory with sign/zero extension.
    function automatic logic [31:0] lsu_model(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        w = mem[a[3:0]];
        case (f3)
            LB:      return {{24{w[7]}}, w[7:0]};
            LH:      return {{16{w[15]}}, w[15:0]};
            LBU:     return {24'h0, w[7:0]};
            LHU:     return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Issue one request and check timing, LSU drive, response payload and handshake.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] tag,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int hold, input string name);
        int lat, exp_c, idx;
        logic seen;
        lat   = use3 ? 3 : 1;
        exp_c = exp_err ? 1 : (we ? 2 : 2 + lat);
        idx   = use3 ? 1 : 0;
        seen  = 1'b0;
        rsp_ready = (hold == 0);
        @(negedge clk);
        checks++;
        if (req_ready_m !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready: got %b want 1", name, req_ready_m);
        end
        req_addr = addr; req_wdata = wdata; req_we = we; req_funct3 = f3; req_tag = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            lsu_dout = (!we && !exp_err && c == 1 + lat) ? lsu_model(addr, f3) : 32'hdeadbeef;
            checks++;
            if (lsu_wren_m !== (c == 1 && we && !exp_err)) begin
                failures++;
                $display("FAIL %s wren cycle %0d: got %b", name, c, lsu_wren_m);
            end
            if (!exp_err && c < exp_c) begin
                checks++;
                if (lsu_address_m !== addr || lsu_funct3_m !== f3 || lsu_din_m !== wdata) begin
                    failures++;
                    $display("FAIL %s lsu_drive cycle %0d: got %h/%b/%h want %h/%b/%h", name, c,
                             lsu_address_m, lsu_funct3_m, lsu_din_m, addr, f3, wdata);
                end
            end
            if (rsp_valid_m === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (c != exp_c) begin
                    failures++;
                    $display("FAIL %s latency: got %0d want %0d", name, c, exp_c);
                end
                checks++;
                if (rsp_data_m !== exp_data || rsp_tag_m !== tag || rsp_err_m !== exp_err ||
                    rsp_is_load_m !== !we) begin
                    failures++;
                    $display("FAIL %s rsp: got d=%h t=%0d e=%b l=%b want d=%h t=%0d e=%b l=%b",
                             name, rsp_data_m, rsp_tag_m, rsp_err_m, rsp_is_load_m,
                             exp_data, tag, exp_err, !we);
                end
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got no rsp_valid want rsp_valid", name);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_m !== 1'b1 || rsp_data_m !== exp_data || req_ready_m !== 1'b0) begin
                failures++;
                $display("FAIL %s stall %0d: got v=%b d=%h rdy=%b want 1/%h/0",
                         name, k, rsp_valid_m, rsp_data_m, req_ready_m, exp_data);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        lsu_dout = 32'hdeadbeef;
        checks++;
        if (rsp_valid_m !== 1'b0 || req_ready_m !== 1'b1) begin
            failures++;
            $display("FAIL %s back_idle: got v=%b rdy=%b want 0/1", name, rsp_valid_m, req_ready_m);
        end
        if (exp_err) exp_er[idx]++;
        else if (we) exp_st[idx]++;
        else exp_ld[idx]++;
        if (we && !exp_err) begin
            case (f3)
                SB:      mem[addr[3:0]][7:0]  = wdata[7:0];
                SH:      mem[addr[3:0]][15:0] = wdata[15:0];
                default: mem[addr[3:0]]       = wdata;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; use3 = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_addr = '0; req_wdata = '0; req_we = 1'b0; req_funct3 = '0; req_tag = '0;
        lsu_dout = 32'hdeadbeef;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready1 !== 1'b0 || rsp_valid1 !== 1'b0 || rsp_data1 !== 32'h0 ||
            rsp_tag1 !== 5'h0 || rsp_err1 !== 1'b0 || rsp_is_load1 !== 1'b0 ||
            lsu_wren1 !== 1'b0 || lsu_address1 !== 32'h0 || lsu_funct31 !== 3'h0 ||
            lsu_din1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h t=%0d wr=%b a=%h want all 0",
                     req_ready1, rsp_valid1, rsp_data1, rsp_tag1, lsu_wren1, lsu_address1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low: got %b want 0", req_ready1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready1 !== 1'b1 || req_ready3 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b/%b want 1/1", req_ready1, req_ready3);
        end
    endtask

    task automatic test_store_load();
        do_req(1'b1, SW, 32'd1, 32'hf0f0f0f0, 5'd1, 32'h0, 1'b0, 0, "sw_1");
        do_req(1'b0, LW, 32'd1, 32'h0, 5'd2, 32'hf0f0f0f0, 1'b0, 0, "lw_1");
    endtask

    task automatic test_subword();
        do_req(1'b1, SH, 32'd2, 32'hffffffff, 5'd4, 32'h0, 1'b0, 0, "sh_2");
        do_req(1'b0, LH, 32'd1, 32'h0, 5'd7, 32'hfffff0f0, 1'b0, 0, "lh_1");
        do_req(1'b0, LHU, 32'd1, 32'h0, 5'd7, 32'h0000f0f0, 1'b0, 0, "lhu_1");
        do_req(1'b0, LH, 32'd2, 32'h0, 5'd8, 32'hffffffff, 1'b0, 0, "lh_2");
        do_req(1'b0, LBU, 32'd1, 32'h0, 5'd9, 32'h000000f0, 1'b0, 0, "lbu_1");
        do_req(1'b1, SB, 32'd2, 32'h00000012, 5'd10, 32'h0, 1'b0, 0, "sb_2");
        do_req(1'b0, LW, 32'd2, 32'h0, 5'd11, 32'h0000ff12, 1'b0, 0, "lw_2_after_sb");
    endtask

    task automatic test_illegal();
        do_req(1'b0, 3'b011, 32'd1, 32'h0, 5'd3, 32'h0, 1'b1, 0, "ld_f3_011");
        do_req(1'b1, 3'b100, 32'd1, 32'h12345678, 5'd5, 32'h0, 1'b1, 0, "st_f3_100");
        do_req(1'b0, 3'b111, 32'd1, 32'h0, 5'd31, 32'h0, 1'b1, 0, "ld_f3_111");
    endtask

    task automatic test_stall();
        do_req(1'b0, LW, 32'd1, 32'h0, 5'd12, 32'hf0f0f0f0, 1'b0, 5, "lw_stall5");
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, SW, 32'd4, 32'h12345678, 5'd13, 32'h0, 1'b0, 0, "b2b_sw");
        do_req(1'b0, LW, 32'd4, 32'h0, 5'd14, 32'h12345678, 1'b0, 0, "b2b_lw");
        do_req(1'b0, LB, 32'd4, 32'h0, 5'd15, 32'h00000078, 1'b0, 0, "b2b_lb");
    endtask

    task automatic test_latency3();
        use3 = 1'b1;
        do_req(1'b1, SW, 32'd5, 32'ha5a5a5a5, 5'd20, 32'h0, 1'b0, 0, "l3_sw");
        do_req(1'b0, LW, 32'd5, 32'h0, 5'd21, 32'ha5a5a5a5, 1'b0, 0, "l3_lw_5");
        do_req(1'b0, LW, 32'd1, 32'h0, 5'd22, 32'hf0f0f0f0, 1'b0, 0, "l3_lw_1");
        do_req(1'b0, LHU, 32'd5, 32'h0, 5'd23, 32'h0000a5a5, 1'b0, 2, "l3_lhu_stall");
`ifdef LOAD_STORE_ISSUER_STATS_EN
        checks++;
        if (ld_cnt3 !== 32'(exp_ld[1]) || st_cnt3 !== 32'(exp_st[1]) ||
            er_cnt3 !== 32'(exp_er[1])) begin
            failures++;
            $display("FAIL stats_l3: got %0d/%0d/%0d want %0d/%0d/%0d",
                     ld_cnt3, st_cnt3, er_cnt3, exp_ld[1], exp_st[1], exp_er[1]);
        end
`endif
        use3 = 1'b0;
    endtask

    task automatic test_stats();
`ifdef LOAD_STORE_ISSUER_STATS_EN
        checks++;
        if (ld_cnt1 !== 32'(exp_ld[0]) || st_cnt1 !== 32'(exp_st[0]) ||
            er_cnt1 !== 32'(exp_er[0])) begin
            failures++;
            $display("FAIL stats_l1: got %0d/%0d/%0d want %0d/%0d/%0d",
                     ld_cnt1, st_cnt1, er_cnt1, exp_ld[0], exp_st[0], exp_er[0]);
        end
`endif
    endtask

    task automatic test_reset_mid_store();
        rsp_ready = 1'b1;
        @(negedge clk);
        req_addr = 32'd3; req_wdata = 32'h55; req_we = 1'b1; req_funct3 = SB; req_tag = 5'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_wren1 !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_issue_wren: got %b want 1", lsu_wren1);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (lsu_wren1 !== 1'b0 || rsp_valid1 !== 1'b0 || req_ready1 !== 1'b0 ||
            lsu_address1 !== 32'h0 || rsp_tag1 !== 5'h0) begin
            failures++;
            $display("FAIL mid_rst_async: got wr=%b v=%b rdy=%b a=%h t=%0d want 0/0/0/0/0",
                     lsu_wren1, rsp_valid1, req_ready1, lsu_address1, rsp_tag1);
        end
        for (int i = 0; i < 2; i++) begin
            exp_ld[i] = 0; exp_st[i] = 0; exp_er[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready1 !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_release_ready: got %b want 1", req_ready1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid1 !== 1'b0 || lsu_wren1 !== 1'b0) begin
                failures++;
                $display("FAIL mid_rst_no_rsp %0d: got v=%b wr=%b want 0/0", i, rsp_valid1,
                         lsu_wren1);
            end
        end
        test_stats();
        do_req(1'b0, LW, 32'd1, 32'h0, 5'd6, 32'hf0f0f0f0, 1'b0, 0, "post_rst_lw");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_ld[i] = 0; exp_st[i] = 0; exp_er[i] = 0;
        end
        test_reset();
        test_store_load();
        test_subword();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_stats();
        test_latency3();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
